// File: rtl/conv_tile_scheduler.sv
// Tile sequencer for a PE_SIZE x PE_SIZE systolic convolution array: walks output-channel
// and input-channel tiles, hands base addresses to the data mover and drains the array.
module conv_tile_scheduler #(
  parameter int PE_SIZE      = 16,
  parameter int DRAIN_CYCLES = 2*PE_SIZE-1,
  parameter int W_ADDR_WIDTH = 16,
  parameter int A_ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [7:0]              cfg_oc_tiles_i,
  input  logic [7:0]              cfg_ic_tiles_i,
  input  logic [9:0]              cfg_rows_i,
  input  logic                    mover_done_i,
  output logic                    mover_en_o,
  output logic [W_ADDR_WIDTH-1:0] w_base_o,
  output logic [A_ADDR_WIDTH-1:0] a_base_o,
  output logic                    acc_clear_o,
  output logic                    last_ic_o,
  output logic                    drain_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, RUN, STEP, DRAIN, DONE} state_t;

  state_t         state;
  logic [7:0]     oc_tiles;
  logic [7:0]     ic_tiles;
  logic [7:0]     oc_idx;
  logic [7:0]     ic_idx;
  logic [9:0]     rows;
  logic [DCW-1:0] drain_cnt;
  logic           done_seen;
  logic [7:0]     oc_last;
  logic [7:0]     ic_last;

  assign oc_last = oc_tiles - 8'd1;
  assign ic_last = ic_tiles - 8'd1;

  // mover_done is captured into done_seen first, so RUN lasts one cycle past the sampled pulse.
  // All outputs are registered and updated on the same transitions as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      oc_tiles    <= '0;
      ic_tiles    <= '0;
      rows        <= '0;
      oc_idx      <= '0;
      ic_idx      <= '0;
      drain_cnt   <= '0;
      done_seen   <= 1'b0;
      mover_en_o  <= 1'b0;
      w_base_o    <= '0;
      a_base_o    <= '0;
      acc_clear_o <= 1'b0;
      last_ic_o   <= 1'b0;
      drain_o     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      acc_clear_o <= 1'b0;
      done_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            oc_tiles <= cfg_oc_tiles_i;
            ic_tiles <= cfg_ic_tiles_i;
            rows     <= cfg_rows_i;
            oc_idx   <= '0;
            ic_idx   <= '0;
            w_base_o <= '0;
            a_base_o <= '0;
            busy_o   <= 1'b1;
            if (cfg_oc_tiles_i == 8'd0 || cfg_ic_tiles_i == 8'd0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state       <= RUN;
              mover_en_o  <= 1'b1;
              acc_clear_o <= 1'b1;
              last_ic_o   <= (cfg_ic_tiles_i == 8'd1);
            end
          end
        end
        RUN: begin
          if (done_seen) begin
            state      <= STEP;
            done_seen  <= 1'b0;
            mover_en_o <= 1'b0;
            last_ic_o  <= 1'b0;
          end else if (mover_done_i) begin
            done_seen <= 1'b1;
          end
        end
        STEP: begin
          w_base_o <= w_base_o + W_ADDR_WIDTH'(PE_SIZE);
          if (ic_idx < ic_last) begin
            ic_idx     <= ic_idx + 8'd1;
            a_base_o   <= a_base_o + A_ADDR_WIDTH'(rows);
            state      <= RUN;
            mover_en_o <= 1'b1;
            last_ic_o  <= ((ic_idx + 8'd1) == ic_last);
          end else begin
            ic_idx    <= '0;
            a_base_o  <= '0;
            drain_cnt <= '0;
            state     <= DRAIN;
            drain_o   <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DCW'(DRAIN_CYCLES-1)) begin
            drain_o <= 1'b0;
            if (oc_idx < oc_last) begin
              oc_idx      <= oc_idx + 8'd1;
              state       <= RUN;
              mover_en_o  <= 1'b1;
              acc_clear_o <= 1'b1;
              last_ic_o   <= (ic_last == 8'd0);
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Scoreboard bench for conv_tile_scheduler: jobs push expected tile/drain/done events,
// a monitor pops and compares them as the scheduler presents them.
module tb_conv_tile_scheduler;

  localparam int PE = 16;
  localparam int DC = 31;
  localparam int K_TILE = 0;
  localparam int K_RUNEND = 1;
  localparam int K_DRAINEND = 2;
  localparam int K_DONE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  cfg_oc_tiles_i = '0;
  logic [7:0]  cfg_ic_tiles_i = '0;
  logic [9:0]  cfg_rows_i = '0;
  logic        mover_done_i = 1'b0;
  logic        mover_en_o;
  logic [15:0] w_base_o;
  logic [15:0] a_base_o;
  logic        acc_clear_o;
  logic        last_ic_o;
  logic        drain_o;
  logic        busy_o;
  logic        done_o;

  typedef struct {
    int kind;
    int w;
    int a;
    int off;
    int len;
    int acc;
    int last;
  } item_t;

  item_t expq[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  int    mover_delay = 4;
  bit    noise_en = 1'b0;
  int    last_a = -1;

  conv_tile_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .cfg_oc_tiles_i (cfg_oc_tiles_i),
    .cfg_ic_tiles_i (cfg_ic_tiles_i),
    .cfg_rows_i     (cfg_rows_i),
    .mover_done_i   (mover_done_i),
    .mover_en_o     (mover_en_o),
    .w_base_o       (w_base_o),
    .a_base_o       (a_base_o),
    .acc_clear_o    (acc_clear_o),
    .last_ic_o      (last_ic_o),
    .drain_o        (drain_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic popExpect(input int kind, output item_t it, output bit ok);
    it = '{default: 0};
    if (expq.size() == 0) begin
      checkOutput("unexpected_event", kind, -1);
      ok = 1'b0;
    end else begin
      it = expq.pop_front();
      checkOutput("event_kind", kind, it.kind);
      ok = (kind == it.kind);
    end
  endtask

  // Data-mover model: answers each mover_en rise with a one-cycle done after mover_delay cycles
  initial begin
    bit prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mover_en_o && !prev) begin
        prev = 1'b1;
        repeat (mover_delay) @(posedge clk);
        #1 mover_done_i = 1'b1;
        @(posedge clk);
        #1 mover_done_i = 1'b0;
      end else begin
        prev = mover_en_o;
      end
    end
  end

  // Disturbance: stray start pulses in RUN and DRAIN, stray mover_done in DRAIN
  initial begin
    bit pen = 1'b0;
    bit pdr = 1'b0;
    bit ren;
    bit rdr;
    forever begin
      @(negedge clk);
      ren = mover_en_o && !pen;
      rdr = drain_o && !pdr;
      pen = mover_en_o;
      pdr = drain_o;
      if (noise_en && (ren || rdr)) begin
        @(posedge clk);
        #1 start_i = 1'b1;
        if (rdr) mover_done_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        if (rdr) mover_done_i = 1'b0;
      end
    end
  end

  // Monitor: drain end is handled before a new tile start since both happen on the same edge
  initial begin
    bit    pen = 1'b0;
    bit    pdr = 1'b0;
    bit    ok;
    int    rlen = 0;
    int    acnt = 0;
    int    lcnt = 0;
    int    dlen = 0;
    int    bcnt = 0;
    item_t it;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pen = 1'b0; pdr = 1'b0;
        rlen = 0; acnt = 0; lcnt = 0; dlen = 0; bcnt = 0;
      end else begin
        if (drain_o) begin
          dlen++;
        end else if (pdr) begin
          popExpect(K_DRAINEND, it, ok);
          if (ok) checkOutput("drain_len", dlen, it.len);
          dlen = 0;
        end
        if (mover_en_o) begin
          if (!pen) begin
            popExpect(K_TILE, it, ok);
            last_a = int'(a_base_o);
            if (ok) begin
              checkOutput("tile_w_base", int'(w_base_o), it.w);
              checkOutput("tile_a_base", int'(a_base_o), it.a);
              checkOutput("tile_start_cycle", cyc - start_cyc, it.off);
            end
          end
          rlen++;
          acnt += int'(acc_clear_o);
          lcnt += int'(last_ic_o);
        end else begin
          if (pen) begin
            popExpect(K_RUNEND, it, ok);
            if (ok) begin
              checkOutput("run_len", rlen, it.len);
              checkOutput("acc_clear_cycles", acnt, it.acc);
              checkOutput("last_ic_cycles", lcnt, it.last);
            end
            rlen = 0; acnt = 0; lcnt = 0;
          end
          checkOutput("flags_outside_run", int'({acc_clear_o, last_ic_o}), 0);
        end
        if (busy_o) bcnt++;
        if (done_o) begin
          popExpect(K_DONE, it, ok);
          if (ok) begin
            checkOutput("done_cycle", cyc - start_cyc, it.off);
            checkOutput("busy_cycles", bcnt, it.len);
          end
        end
        if (!busy_o) bcnt = 0;
        pen = mover_en_o;
        pdr = drain_o;
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, int'({mover_en_o, acc_clear_o, last_ic_o, drain_o, busy_o, done_o}), 0);
    checkOutput({tag, "_w_base"}, int'(w_base_o), 0);
    checkOutput({tag, "_a_base"}, int'(a_base_o), 0);
  endtask

  // Pushes the expected event stream of one job, starts it, then waits for done (or aborts in DRAIN)
  task automatic applyStimulus(input int oc, input int ic, input int rows, input int d,
                               input bit noise, input bit abort_in_drain);
    item_t it;
    int    tile_cyc = d + 3;
    int    passes = abort_in_drain ? 1 : oc;
    int    total = (oc == 0 || ic == 0) ? 1 : oc * (ic * tile_cyc + DC) + 1;
    bit    seen = 1'b0;
    if (ic > 0) begin
      for (int o = 0; o < passes; o++) begin
        for (int i = 0; i < ic; i++) begin
          it = '{default: 0};
          it.kind = K_TILE;
          it.w = ((o * ic + i) * PE) % 65536;
          it.a = (i * rows) % 65536;
          it.off = 1 + o * (ic * tile_cyc + DC) + i * tile_cyc;
          expq.push_back(it);
          it = '{default: 0};
          it.kind = K_RUNEND;
          it.len = d + 2;
          it.acc = (i == 0) ? 1 : 0;
          it.last = (i == ic - 1) ? d + 2 : 0;
          expq.push_back(it);
        end
        if (!abort_in_drain) begin
          it = '{default: 0};
          it.kind = K_DRAINEND;
          it.len = DC;
          expq.push_back(it);
        end
      end
    end
    if (!abort_in_drain) begin
      it = '{default: 0};
      it.kind = K_DONE;
      it.off = total;
      it.len = total;
      expq.push_back(it);
    end
    mover_delay = d;
    noise_en = noise;
    @(posedge clk);
    #1;
    cfg_oc_tiles_i = 8'(oc);
    cfg_ic_tiles_i = 8'(ic);
    cfg_rows_i = 10'(rows);
    start_i = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    cfg_oc_tiles_i = 8'hA5;
    cfg_ic_tiles_i = 8'h5A;
    cfg_rows_i = 10'h3FF;
    if (abort_in_drain) begin
      for (int k = 0; k < ic * tile_cyc + 20; k++) begin
        @(negedge clk);
        if (drain_o) begin
          seen = 1'b1;
          break;
        end
      end
      checkOutput("drain_reached", int'(seen), 1);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 checkAllZero("mid_job_reset");
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1 checkAllZero("after_reset");
    end else begin
      for (int k = 0; k < total + 50; k++) begin
        @(negedge clk);
        if (done_o) begin
          seen = 1'b1;
          break;
        end
      end
      checkOutput("job_done_seen", int'(seen), 1);
    end
    noise_en = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("queue_drained", expq.size(), 0);
    expq.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 checkAllZero("reset_state");
    rst_n = 1'b1;
    applyStimulus(1, 1, 64, 4, 1'b0, 1'b0);
    applyStimulus(2, 3, 100, 2, 1'b0, 1'b0);
    applyStimulus(0, 5, 50, 2, 1'b0, 1'b0);
    applyStimulus(3, 0, 50, 2, 1'b0, 1'b0);
    applyStimulus(2, 3, 100, 2, 1'b1, 1'b0);
    applyStimulus(2, 2, 40, 3, 1'b0, 1'b1);
    applyStimulus(2, 2, 7, 3, 1'b0, 1'b0);
    applyStimulus(1, 255, 1023, 1, 1'b0, 1'b0);
    checkOutput("final_a_base", last_a, 63234);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
